// File: rtl/bin2ascii_dec_pkg.sv
// Shared definitions for the bin2ascii_dec formatter: FSM state type,
// ASCII character codes and an elaboration-time power-of-ten helper.
package bin2ascii_dec_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_FORMAT = 2'd2
   } state_e;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_DASH  = 8'h2D;

   // 10^n as a 64-bit constant; only evaluated at elaboration.
   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) begin
         r = r * 64'd10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bin2ascii_dec_bcd_adj3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is >= 5 so the
// following left shift carries correctly into the next decimal digit.
//   i_nib : BCD nibble before correction
//   o_nib : corrected nibble
module bin2ascii_dec_bcd_adj3 (
   input  logic [3:0] i_nib,
   output logic [3:0] o_nib
);

   assign o_nib = (i_nib >= 4'd5) ? i_nib + 4'd3 : i_nib;

endmodule

// File: rtl/bin2ascii_dec.sv
// Sequential binary-to-decimal ASCII formatter for the seven-segment path.
// A start strobe in IDLE latches value; a double-dabble conversion then runs
// one bit per clock, and a final FORMAT cycle writes the ASCII word, the
// overflow flag and a one-cycle done pulse.
//
//   state  | meaning
//   IDLE   | waiting for start, busy=0
//   SHIFT  | one add-3/shift step per edge, WIDTH edges
//   FORMAT | writes word/ovf, pulses done, returns to IDLE
//
// Ports:
//   clk    : system clock
//   reset  : synchronous active-high reset
//   start  : conversion request, sampled in IDLE only
//   value  : unsigned binary input, latched on the accepted start
//   busy   : conversion in progress
//   done   : one-cycle pulse, word/ovf valid from this cycle
//   ovf    : latched value >= 10^DIGITS, held until next done
//   word   : DIGITS ASCII characters, word[7:0] is the least significant digit
module bin2ascii_dec
   import bin2ascii_dec_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 4,
   parameter bit BLANK  = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [WIDTH-1:0]      value,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [DIGITS*8-1:0]   word
);

   localparam int          CNT_W = $clog2(WIDTH + 1);
   localparam int          BCD_W = 4 * DIGITS;
   localparam logic [63:0] LIMIT = pow10(DIGITS);

   state_e              r_state;
   state_e              w_state_nxt;
   logic [WIDTH-1:0]    r_value;
   logic [WIDTH-1:0]    r_bin;
   logic [BCD_W-1:0]    r_bcd;
   logic [BCD_W-1:0]    w_bcd_adj;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_done;
   logic                r_ovf;
   logic [DIGITS*8-1:0] r_word;
   logic [DIGITS*8-1:0] w_word;
   logic                w_last_shift;
   logic                w_ovf;

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bin2ascii_dec_bcd_adj3 u_adj (
         .i_nib (r_bcd[4*g +: 4]),
         .o_nib (w_bcd_adj[4*g +: 4])
      );
   end

   assign w_last_shift = (r_cnt == CNT_W'(WIDTH - 1));
   // The untouched copy of the input decides overflow; the shift register
   // has been consumed by the time FORMAT runs.
   assign w_ovf        = (64'(r_value) >= LIMIT);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_state_nxt = ST_SHIFT;
         ST_SHIFT:  if (w_last_shift) w_state_nxt = ST_FORMAT;
         ST_FORMAT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   // Leading-zero blanking scans from the most significant digit; digit 0 is
   // always printed so a zero value shows a single '0'.
   always_comb begin : p_format
      logic       lead;
      logic [3:0] nib;
      w_word = '0;
      lead   = BLANK;
      nib    = '0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = r_bcd[4*i +: 4];
         if (w_ovf) begin
            w_word[8*i +: 8] = ASCII_DASH;
         end else if (lead && (i != 0) && (nib == 4'd0)) begin
            w_word[8*i +: 8] = ASCII_SPACE;
         end else begin
            w_word[8*i +: 8] = ASCII_ZERO + {4'h0, nib};
            lead             = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_value <= '0;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_ovf   <= 1'b0;
         r_word  <= {DIGITS{ASCII_SPACE}};
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_value <= value;
                  r_bin   <= value;
                  r_bcd   <= '0;
                  r_cnt   <= '0;
               end
            end
            ST_SHIFT: begin
               {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
               r_cnt          <= r_cnt + CNT_W'(1);
            end
            ST_FORMAT: begin
               r_word <= w_word;
               r_ovf  <= w_ovf;
               r_done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = r_done;
   assign ovf  = r_ovf;
   assign word = r_word;

endmodule
